// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, redirect squash, data-memory freeze.
// Outputs are combinational from state and inputs with zero latency; a pending dmem access freezes all stages until ack or timeout.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_redirect,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic             exmem_bubble,
  output logic             dmem_valid,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam logic [7:0] TO_W = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             lu;

  assign lu = ex_MemRead && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    err_d        = err_q;
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_flush   = 1'b0;
    exmem_hold   = 1'b0;
    exmem_bubble = 1'b0;
    dmem_valid   = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !dmem_ack) begin
          // Redirect and load-use wait until the freeze ends; their inputs stay stable meanwhile.
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
          dmem_valid = 1'b1;
          state_d    = MEM_WAIT;
          wait_d     = 8'd1;
        end else if (mem_redirect) begin
          ifid_flush   = 1'b1;
          idex_flush   = 1'b1;
          exmem_bubble = 1'b1;
          dmem_valid   = mem_req;
        end else if (lu) begin
          pc_hold    = 1'b1;
          ifid_hold  = 1'b1;
          idex_flush = 1'b1;
          dmem_valid = mem_req;
        end else begin
          dmem_valid = mem_req;
        end
      end
      MEM_WAIT: begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
        dmem_valid = 1'b1;
        if (dmem_ack) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == TO_W) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ERROR: begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (!rstn) begin
      pc_hold      = 1'b0;
      ifid_hold    = 1'b0;
      ifid_flush   = 1'b0;
      idex_hold    = 1'b0;
      idex_flush   = 1'b0;
      exmem_hold   = 1'b0;
      exmem_bubble = 1'b0;
      dmem_valid   = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (pc_hold && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign mem_timeout_err = err_q;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int TO    = 4;
  localparam int CNT_W = 16;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_MemRead, mem_redirect, mem_req, dmem_ack;
  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, exmem_bubble, dmem_valid;
  logic mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [7:0] obs;

  int errors = 0;
  int checks = 0;

  // Reference model state: frozen-on-memory flag, cycles waited, sticky error, stall count.
  bit m_wait, m_err;
  int m_cnt, m_stall;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
    .mem_redirect(mem_redirect), .mem_req(mem_req), .dmem_ack(dmem_ack),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_hold(idex_hold),
    .idex_flush(idex_flush), .exmem_hold(exmem_hold), .exmem_bubble(exmem_bubble),
    .dmem_valid(dmem_valid), .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign obs = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, exmem_bubble, dmem_valid};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Bit order: pc_hold ifid_hold ifid_flush idex_hold idex_flush exmem_hold exmem_bubble dmem_valid
  function automatic logic [7:0] model_out();
    bit lu;
    lu = ex_MemRead && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!rstn) return 8'h00;
    if (m_err) return 8'hD4;
    if (m_wait || (mem_req && !dmem_ack)) return 8'hD5;
    if (mem_redirect) return 8'h2A | {7'd0, mem_req};
    if (lu) return 8'hC8 | {7'd0, mem_req};
    return {7'd0, mem_req};
  endfunction

  // Called at a negedge with inputs applied; checks, advances one clock, returns at next negedge.
  task automatic cyc();
    logic [7:0] e;
    #1;
    e = model_out();
    chk("outs", obs, e);
    chk("err", mem_timeout_err, m_err);
    chk("stall", stall_cycles, m_stall);
    @(posedge clk);
    if (rstn) begin
      if (e[7] && m_stall < SMAX) m_stall++;
      if (!m_err) begin
        if (m_wait) begin
          if (dmem_ack) begin m_wait = 0; m_cnt = 0; end
          else if (m_cnt == TO) m_err = 1;
          else m_cnt++;
        end else if (mem_req && !dmem_ack) begin
          m_wait = 1; m_cnt = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_outs", obs, 8'h00);
    chk("rst_err", mem_timeout_err, 0);
    chk("rst_stall", stall_cycles, 0);
    m_wait = 0; m_cnt = 0; m_err = 0; m_stall = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_MemRead = 0; ex_rd = 0; mem_redirect = 0; mem_req = 0; dmem_ack = 0;
  endtask

  initial begin
    rstn = 1'b0;
    id_rs1 = 5; id_rs2 = 5; id_use_rs1 = 1; id_use_rs2 = 1;
    ex_MemRead = 1; ex_rd = 5; mem_redirect = 1; mem_req = 1; dmem_ack = 0;
    @(negedge clk);
    do_reset();
    idle_inputs();
    cyc();

    // Load-use through rs2: one bubble, then load moves to MEM.
    ex_MemRead = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 3; id_use_rs1 = 1;
    #1 chk("lu_stall", obs, 8'hC8);
    cyc();
    ex_MemRead = 0;
    #1 chk("lu_after", obs, 8'h00);
    cyc();
    chk("lu_cnt", stall_cycles, 1);

    // Destination x0 never creates a hazard.
    ex_MemRead = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
    #1 chk("lu_x0", obs, 8'h00);
    cyc();

    // Redirect wins over a simultaneous load-use.
    ex_rd = 5; id_rs2 = 5; mem_redirect = 1;
    #1 chk("redir_lu", obs, 8'h2A);
    cyc();
    chk("redir_cnt", stall_cycles, 1);
    idle_inputs();

    // Ack on the third cycle after request: four frozen cycles.
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      dmem_ack = (i == 3);
      #1 chk("mem3_frz", obs, 8'hD5);
      cyc();
    end
    mem_req = 0; dmem_ack = 0;
    #1 chk("mem3_resume", obs, 8'h00);
    chk("mem3_cnt", stall_cycles, 4);
    cyc();

    // Single-cycle access: no stall.
    mem_req = 1; dmem_ack = 1;
    #1 chk("mem1", obs, 8'h01);
    cyc();
    chk("mem1_cnt", stall_cycles, 4);

    // Timeout: no ack for cycles 0..TO.
    mem_req = 1; dmem_ack = 0;
    for (int i = 0; i <= TO; i++) begin
      #1 chk("to_wait_err", mem_timeout_err, 0);
      cyc();
    end
    #1 chk("to_err", mem_timeout_err, 1);
    chk("to_outs", obs, 8'hD4);
    dmem_ack = 1;
    cyc();
    cyc();
    chk("to_ack_ignored", mem_timeout_err, 1);
    do_reset();
    idle_inputs();
    cyc();

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if (m_err && $urandom_range(0, 9) == 0) do_reset();
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      ex_MemRead = 1'($urandom_range(0, 1));
      mem_redirect = ($urandom_range(0, 5) == 0);
      mem_req = ($urandom_range(0, 2) == 0);
      dmem_ack = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // Saturation of the stall counter while parked in ERROR.
    do_reset();
    idle_inputs();
    mem_req = 1;
    for (int n = 0; n < 70000; n++) cyc();
    chk("stall_sat", stall_cycles, 16'hFFFF);
    cyc();
    chk("stall_nowrap", stall_cycles, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
